// File: rtl/image_pkg.sv
// rtl/image_pkg.sv - shared constants, sync-guard states and shift clamp for the XY decimator
package image_pkg;

    localparam int MAX_SHIFT      = 2;
    localparam int ACC_GUARD_BITS = 2;

    typedef enum logic {
        SYNC_WAIT = 1'b0,
        SYNC_RUN  = 1'b1
    } sync_state_t;

    function automatic logic [1:0] clamp_shift(input logic [1:0] shift);
        return (shift > 2'(MAX_SHIFT)) ? 2'(MAX_SHIFT) : shift;
    endfunction

endpackage

// File: rtl/image_xy_decimate_if.sv
// rtl/image_xy_decimate_if.sv - vsync/href/de/data image stream bundle
interface image_xy_decimate_if #(
    parameter int PIXEL_DATA_WIDTH = 8
);

    logic                        vsync;
    logic                        href;
    logic                        de;
    logic [PIXEL_DATA_WIDTH-1:0] data;

    modport master (output vsync, href, de, data);
    modport slave  (input  vsync, href, de, data);

endinterface

// File: rtl/image_decim_hacc.sv
// rtl/image_decim_hacc.sv - horizontal group-phase counter, optional group averager (IMAGE_DECIM_AVG_EN)
module image_decim_hacc
    import image_pkg::*;
#(
    parameter int PIXEL_DATA_WIDTH = 8,
    parameter int H_COUNTER_WIDTH  = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        href,
    input  logic                        de,
    input  logic [PIXEL_DATA_WIDTH-1:0] data,
    input  logic [1:0]                  h_shift,
    output logic                        emit,
    output logic [PIXEL_DATA_WIDTH-1:0] pix
);

    logic [H_COUNTER_WIDTH-1:0] xpos;
    logic [H_COUNTER_WIDTH-1:0] phase_mask;
    logic [H_COUNTER_WIDTH-1:0] phase;

    assign phase_mask = H_COUNTER_WIDTH'((1 << h_shift) - 1);
    assign phase      = xpos & phase_mask;

    // Wraps silently; frame widths stay below 2^H_COUNTER_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xpos <= '0;
        end else if (!href) begin
            xpos <= '0;
        end else if (de) begin
            xpos <= xpos + 1'b1;
        end
    end

`ifdef IMAGE_DECIM_AVG_EN
    localparam int ACC_W = PIXEL_DATA_WIDTH + ACC_GUARD_BITS;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_sum;

    // Phase 0 restarts the group, so the previous group's sum is never carried in.
    assign acc_sum = ((phase == '0) ? '0 : acc_q) + ACC_W'(data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (!href) begin
            acc_q <= '0;
        end else if (de) begin
            acc_q <= acc_sum;
        end
    end

    assign emit = de && (phase == phase_mask);
    assign pix  = PIXEL_DATA_WIDTH'(acc_sum >> h_shift);
`else
    assign emit = de && (phase == '0);
    assign pix  = data;
`endif

endmodule

// File: rtl/image_xy_decimate.sv
// rtl/image_xy_decimate.sv - power-of-two XY decimator; IMAGE_DECIM_AVG_EN selects horizontal averaging
module image_xy_decimate
    import image_pkg::*;
#(
    parameter int PIXEL_DATA_WIDTH = 8,
    parameter int H_COUNTER_WIDTH  = 12,
    parameter int V_COUNTER_WIDTH  = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 h_shift_i,
    input  logic [1:0]                 v_shift_i,
    image_xy_decimate_if.slave         image_in,
    image_xy_decimate_if.master        image_out
);

    sync_state_t                 sync_q;
    sync_state_t                 sync_d;
    logic                        vsync_d;
    logic                        href_d;
    logic [1:0]                  h_shift_q;
    logic [1:0]                  v_shift_q;
    logic [1:0]                  h_shift_eff;
    logic [1:0]                  v_shift_eff;
    logic                        vsync_rise;
    logic                        href_fall;
    logic [V_COUNTER_WIDTH-1:0]  ypos;
    logic [V_COUNTER_WIDTH-1:0]  v_mask;
    logic                        line_keep;
    logic                        in_de;
    logic                        hacc_emit;
    logic [PIXEL_DATA_WIDTH-1:0] hacc_pix;
    logic                        pix_take;

    logic                        out_vsync_q;
    logic                        out_href_q;
    logic                        out_de_q;
    logic [PIXEL_DATA_WIDTH-1:0] out_data_q;

    assign vsync_rise = image_in.vsync & ~vsync_d;
    assign href_fall  = href_d & ~image_in.href;

    // The rising-edge cycle already sees the new factors so the first line uses them.
    assign h_shift_eff = vsync_rise ? clamp_shift(h_shift_i) : h_shift_q;
    assign v_shift_eff = vsync_rise ? clamp_shift(v_shift_i) : v_shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d   <= 1'b0;
            href_d    <= 1'b0;
            h_shift_q <= 2'd0;
            v_shift_q <= 2'd0;
        end else begin
            vsync_d   <= image_in.vsync;
            href_d    <= image_in.href;
            h_shift_q <= h_shift_eff;
            v_shift_q <= v_shift_eff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= SYNC_WAIT;
        end else begin
            sync_q <= sync_d;
        end
    end

    // A frame already running when reset releases is dropped until vsync goes low.
    always_comb begin
        sync_d = sync_q;
        if (sync_q == SYNC_WAIT && !image_in.vsync) begin
            sync_d = SYNC_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ypos <= '0;
        end else if (!image_in.vsync) begin
            ypos <= '0;
        end else if (href_fall) begin
            ypos <= ypos + 1'b1;
        end
    end

    assign v_mask    = V_COUNTER_WIDTH'((1 << v_shift_eff) - 1);
    assign line_keep = ((ypos & v_mask) == '0);
    assign in_de     = image_in.de & image_in.href;

    image_decim_hacc #(
        .PIXEL_DATA_WIDTH (PIXEL_DATA_WIDTH),
        .H_COUNTER_WIDTH  (H_COUNTER_WIDTH)
    ) u_hacc (
        .clk     (clk),
        .rst_n   (rst_n),
        .href    (image_in.href),
        .de      (in_de),
        .data    (image_in.data),
        .h_shift (h_shift_eff),
        .emit    (hacc_emit),
        .pix     (hacc_pix)
    );

    assign pix_take = hacc_emit & line_keep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vsync_q <= 1'b0;
            out_href_q  <= 1'b0;
            out_de_q    <= 1'b0;
            out_data_q  <= '0;
        end else if (sync_q != SYNC_RUN) begin
            out_vsync_q <= 1'b0;
            out_href_q  <= 1'b0;
            out_de_q    <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_vsync_q <= image_in.vsync;
            out_href_q  <= image_in.href & line_keep;
            out_de_q    <= pix_take;
            if (pix_take) begin
                out_data_q <= hacc_pix;
            end
        end
    end

    assign image_out.vsync = out_vsync_q;
    assign image_out.href  = out_href_q;
    assign image_out.de    = out_de_q;
    assign image_out.data  = out_data_q;

endmodule

// File: tb/tb_image_xy_decimate.sv
// tb/tb_image_xy_decimate.sv - directed and randomized frames checked against a coordinate-based model
module tb_image_xy_decimate;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] h_shift_i;
    logic [1:0] v_shift_i;

    image_xy_decimate_if #(.PIXEL_DATA_WIDTH(8)) s_in ();
    image_xy_decimate_if #(.PIXEL_DATA_WIDTH(8)) s_out ();

    image_xy_decimate #(
        .PIXEL_DATA_WIDTH (8),
        .H_COUNTER_WIDTH  (12),
        .V_COUNTER_WIDTH  (12)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .h_shift_i (h_shift_i),
        .v_shift_i (v_shift_i),
        .image_in  (s_in.slave),
        .image_out (s_out.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int de_cnt;
    int m_fx = 1;
    int m_fy = 1;
    bit seen_low = 0;
    logic [7:0] fpix [0:15][0:15];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One input cycle; expected outputs come from frame coordinates (x, y) and the factors.
    task automatic step(input bit vs, input bit hr, input bit de, input int x, input int y);
        bit         keep, sel, ev, eh, ed;
        int         sum;
        logic [7:0] edata;
        s_in.vsync = vs;
        s_in.href  = hr;
        s_in.de    = de;
        s_in.data  = de ? fpix[y][x] : 8'($urandom);
        keep  = (y % m_fy) == 0;
        sel   = 0;
        edata = '0;
        if (de) begin
`ifdef IMAGE_DECIM_AVG_EN
            sel = (x % m_fx) == (m_fx - 1);
            if (sel) begin
                sum = 0;
                for (int k = x - m_fx + 1; k <= x; k++) sum += fpix[y][k];
                edata = 8'(sum / m_fx);
            end
`else
            sel   = (x % m_fx) == 0;
            edata = fpix[y][x];
`endif
        end
        ev = seen_low & vs;
        eh = seen_low & hr & keep;
        ed = seen_low & hr & de & keep & sel;
        @(posedge clk);
        #1;
        chk("vsync", 32'(s_out.vsync), 32'(ev));
        chk("href",  32'(s_out.href),  32'(eh));
        chk("de",    32'(s_out.de),    32'(ed));
        if (ed) chk("data", 32'(s_out.data), 32'(edata));
        if (s_out.de === 1'b1) de_cnt++;
        if (!vs) seen_low = 1;
    endtask

    task automatic run_frame(input int w, input int h, input int hin, input int vin,
                             input bit mid_change, input int rst_line, input bit gaps,
                             input int exp_cnt);
        int lh, lv, x;
        bit rst_done;
        rst_done  = 0;
        lh        = (hin > 2) ? 2 : hin;
        lv        = (vin > 2) ? 2 : vin;
        m_fx      = 1 << lh;
        m_fy      = 1 << lv;
        h_shift_i = 2'(hin);
        v_shift_i = 2'(vin);
        de_cnt    = 0;
        repeat (3) step(0, 0, 0, 0, 0);
        for (int y = 0; y < h; y++) begin
            if (y > 0) repeat (2) step(1, 0, 0, 0, y);
            if (mid_change && y == 1) h_shift_i = 2'd0;
            x = 0;
            while (x < w) begin
                if (y == rst_line && x == 2 && !rst_done) begin
                    rst_done = 1;
                    rst_n    = 1'b0;
                    seen_low = 0;
                    repeat (3) step(1, 1, 0, x, y);
                    rst_n    = 1'b1;
                end
                if (gaps && $urandom_range(0, 3) == 0) begin
                    step(1, 1, 0, x, y);
                end else begin
                    step(1, 1, 1, x, y);
                    x++;
                end
            end
        end
        repeat (2) step(1, 0, 0, 0, h);
        if (exp_cnt >= 0) chk("de_count", 32'(de_cnt), 32'(exp_cnt));
    endtask

    task automatic fill(input int mode);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                case (mode)
                    0:       fpix[y][x] = 8'(8 * y + x);
                    1:       fpix[y][x] = 8'(16 * y + x);
                    default: fpix[y][x] = 8'($urandom);
                endcase
    endtask

    initial begin
        int w, h, hs, vs, fx, fy, cnt;
        rst_n      = 1'b0;
        h_shift_i  = 2'd0;
        v_shift_i  = 2'd0;
        s_in.vsync = 1'b0;
        s_in.href  = 1'b0;
        s_in.de    = 1'b0;
        s_in.data  = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_vsync", 32'(s_out.vsync), 32'd0);
            chk("rst_href",  32'(s_out.href),  32'd0);
            chk("rst_de",    32'(s_out.de),    32'd0);
            chk("rst_data",  32'(s_out.data),  32'd0);
        end
        rst_n = 1'b1;

        fill(0);
        run_frame(8, 4, 0, 0, 0, -1, 0, 32);
        fill(1);
        run_frame(8, 4, 1, 1, 0, -1, 0, 8);

        fill(2);
        fpix[0][0] = 8'd10;  fpix[0][1] = 8'd20;  fpix[0][2] = 8'd30;  fpix[0][3] = 8'd40;
        fpix[0][4] = 8'd255; fpix[0][5] = 8'd255; fpix[0][6] = 8'd255; fpix[0][7] = 8'd255;
        run_frame(8, 1, 2, 0, 0, -1, 0, 2);

        fill(2);
`ifdef IMAGE_DECIM_AVG_EN
        run_frame(6, 2, 2, 0, 0, -1, 0, 2);
`else
        run_frame(6, 2, 2, 0, 0, -1, 0, 4);
`endif

        run_frame(8, 2, 3, 0, 1, -1, 0, 4);
        run_frame(8, 2, 0, 0, 0, -1, 0, 16);

        fill(1);
        run_frame(8, 4, 1, 1, 0, 2, 0, -1);
        run_frame(8, 4, 1, 1, 0, -1, 1, 8);

        for (int i = 0; i < 6; i++) begin
            fill(2);
            w  = $urandom_range(1, 16);
            h  = $urandom_range(1, 8);
            hs = $urandom_range(0, 3);
            vs = $urandom_range(0, 3);
            fx = 1 << ((hs > 2) ? 2 : hs);
            fy = 1 << ((vs > 2) ? 2 : vs);
`ifdef IMAGE_DECIM_AVG_EN
            cnt = (w / fx) * ((h + fy - 1) / fy);
`else
            cnt = ((w + fx - 1) / fx) * ((h + fy - 1) / fy);
`endif
            run_frame(w, h, hs, vs, 0, -1, 1, cnt);
        end

        repeat (3) step(0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/image_xy_decimate.md
# image_xy_decimate

Integer-power-of-two spatial decimator placed directly downstream of the XY crop stage in the sensor image path. Consumes the cropped vsync/href/de/data stream and emits a reduced-resolution stream in the same four-signal format for the next processing stage. Decimation factors are 1, 2 or 4, set independently in X and Y. Factors are sampled once per frame so they never change mid-frame.

## Interface
- PIXEL_DATA_WIDTH, 8, width of one pixel word (single unsigned channel)
- H_COUNTER_WIDTH, 12, width of the horizontal pixel counter
- V_COUNTER_WIDTH, 12, width of the vertical line counter
- clk  in  1  image pixel clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- h_shift_i  in  2  X factor = 2^h_shift_i; value 3 is clamped to 2
- v_shift_i  in  2  Y factor = 2^v_shift_i; value 3 is clamped to 2
- image_in_vsync  in  1  high for the whole valid frame, low during frame sync
- image_in_href  in  1  high for the whole valid line
- image_in_de  in  1  pixel valid qualifier inside href
- image_in_data  in  PIXEL_DATA_WIDTH  pixel word, valid when de=1
- image_out_vsync  out  1  decimated frame valid
- image_out_href  out  1  decimated line valid
- image_out_de  out  1  decimated pixel valid
- image_out_data  out  PIXEL_DATA_WIDTH  decimated pixel word

## Operation
- Config latch: h_shift/v_shift registers load the clamped inputs on the rising edge of image_in_vsync. Reset value of both is 0 (pass-through). Changes at any other time are ignored.
- Sync guard: a `synced` flag clears on reset and sets on the first cycle with image_in_vsync=0. While `synced`=0, all outputs are held at 0. A frame already in progress when reset is released is therefore dropped in full.
- Y phase counter (V_COUNTER_WIDTH): cleared while vsync=0. Increments on each href falling edge. A line is kept when (ypos & (2^v_shift−1)) == 0.
- X phase counter (H_COUNTER_WIDTH): cleared while href=0. Increments on each de=1 cycle.
- Pixel selection without averaging: emit the pixel whose group phase is 0, i.e. the first pixel of each 2^h_shift group. A partial group at line end still emits its first pixel, so output width = ceil(W / 2^h).
- Pixel selection with averaging (see Configuration): emit on the pixel whose group phase is 2^h_shift−1. Partial groups at line end are discarded.
- Dropped lines: href and de are both held low for the full line.
- Counter wrap-around: counters wrap silently modulo 2^width. This is legal only because frame dimensions stay below 2^width.

## Timing
- All outputs are registered. Reset value of every output is 0.
- image_out_vsync = image_in_vsync delayed 1 cycle (gated by `synced`).
- image_out_href = (image_in_href AND line kept) delayed 1 cycle.
- image_out_de is asserted 1 cycle after the selected input de cycle. image_out_data is valid on the same cycle.
- Fixed latency of 1 cycle in both modes. In averaging mode, the latency is measured from the last pixel of the group.
- href falling edge and a de cycle may coincide: the pixel on that cycle belongs to the ending line.
- A vsync rise that coincides with an href rise is legal. The new config applies to that first line.

## Configuration
- IMAGE_DECIM_AVG_EN defined:
  - A horizontal accumulator of width PIXEL_DATA_WIDTH+2 sums the pixels of each group.
  - Emitted data = sum >> h_shift, truncated (no rounding).
  - The accumulator clears at the start of each group and on href=0.
  - Vertical decimation remains line-drop only.
- IMAGE_DECIM_AVG_EN undefined: the accumulator is not instantiated and selection is nearest-neighbour (first pixel of each group).

## Structure
- Shared package image_pkg holds:
  - MAX_SHIFT = 2
  - the clamp function for shift values
  - ACC_GUARD_BITS = 2
- One sub-module, image_decim_hacc: the horizontal group-phase counter plus optional accumulator. It outputs an emit strobe and the pixel word. The top level owns config latching, the sync guard, Y logic and output registers.

## Test plan
- Reset-value and pass-through check: h=v=0, 8×4 frame, data 0..31 → output identical to input delayed 1 cycle; all outputs 0 during reset.
- Nearest-neighbour decimation: h=1, v=1, 8×4 frame, data = 16·y+x → 2 lines out, pixels 0,2,4,6 then 32,34,36,38; lines 1 and 3 have href low.
- Averaging (IMAGE_DECIM_AVG_EN): h=2, line 10,20,30,40,255,255,255,255 → two de pulses carrying 25 and 255, each 1 cycle after the 4th pixel of its group.
- Partial group: h=2, 6-pixel line.
  - Without the macro: 2 pixels out (x=0, x=4).
  - With the macro: 1 pixel out.
- Clamp and mid-frame config: drive h_shift_i=3 before vsync rise → factor 4 is used. Change to 0 mid-frame → no effect until the next vsync rise.
- Reset mid-frame: assert rst_n low during line 2, release while vsync=1 → outputs stay 0 until vsync falls. The next frame is processed normally.
